// File: rtl/back_propagation_output_layer_vector.sv
// rtl/back_propagation_output_layer_vector.sv - output-layer delta vector (node - expected) through one shared fp32 adder
//
// adder_floating_point32: pipelined IEEE-754 single-precision adder, round-to-nearest-even.
//   clk, rstn            clock, asynchronous active-low reset
//   valid_in, inA, inB   operands, accepted every cycle
//   valid_out, outN      sum, LATENCY clocks after valid_in
//
// back_propagation_output_layer_vector: delta[i] = node[i] - expected[i], one element per cycle.
//   clk, rst_n           clock, asynchronous active-low reset
//   i_valid              input vector valid, taken when o_ready is high
//   i_data_node          network outputs, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_data_expected      target values, same packing
//   i_action_mask        1 = element contributes; 0 forces +0.0 when MASK_ENABLE=1
//   o_ready              able to accept a vector (IDLE or DONE)
//   o_delta_node         delta vector, updated all at once
//   o_valid              one-cycle pulse with each new o_delta_node

module adder_floating_point32 #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        valid_out,
  output logic [31:0] outN
);

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ex, ey;
    logic [26:0] mx, my, sh, lost, m;
    logic [8:0]  d;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [24:0] rm;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);
    // x is the larger magnitude, so the result takes its sign
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    // subnormals use exponent 1 with no hidden bit; 3 extra bits are guard/round/sticky
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {|x[30:23], x[22:0], 3'b000};
    my = {|y[30:23], y[22:0], 3'b000};
    d  = {1'b0, ex} - {1'b0, ey};
    if (d >= 9'd27) begin
      sh = {26'd0, |my};
    end else begin
      sh    = my >> d;
      lost  = my << (9'd27 - d);
      sh[0] = sh[0] | (|lost);
    end
    e = {2'b00, ex};
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, sh};
      if (sum[27]) begin
        m    = sum[27:1];
        m[0] = m[0] | sum[0];
        e    = e + 10'd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, sh};
      m   = sum[26:0];
    end
    if (m == 27'd0) begin
      // exact cancellation gives +0; only -0 + -0 keeps the sign
      r = {x[31] & y[31], 31'd0};
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!m[26] && e > 10'd1) begin
          m = m << 1;
          e = e - 10'd1;
        end
      end
      rm = {1'b0, m[26:3]} + {24'd0, m[2] & (m[1] | m[0] | m[3])};
      if (rm[24]) begin
        rm = rm >> 1;
        e  = e + 10'd1;
      end
      if (e >= 10'd255) r = {x[31], 8'hFF, 23'd0};
      else              r = {x[31], (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
    end
    if (a_nan)                               r = a | 32'h0040_0000;
    else if (b_nan)                          r = b | 32'h0040_0000;
    else if (a_inf && b_inf && a[31] != b[31]) r = 32'h7FC0_0000;
    else if (a_inf)                          r = a;
    else if (b_inf)                          r = b;
    return r;
  endfunction

  logic        valid_pipe [LATENCY];
  logic [31:0] data_pipe  [LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_pipe[i] <= 1'b0;
        data_pipe[i]  <= 32'd0;
      end
    end else begin
      valid_pipe[0] <= valid_in;
      data_pipe[0]  <= fadd(inA, inB);
      for (int i = 1; i < LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
      end
    end
  end

  assign valid_out = valid_pipe[LATENCY-1];
  assign outN      = data_pipe[LATENCY-1];

endmodule

module back_propagation_output_layer_vector #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_NODE      = 4,
  parameter int ADDER_LATENCY = 7,
  parameter bit MASK_ENABLE   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH*NUM_NODE-1:0] i_data_node,
  input  logic [DATA_WIDTH*NUM_NODE-1:0] i_data_expected,
  input  logic [NUM_NODE-1:0]            i_action_mask,
  output logic                           o_ready,
  output logic [DATA_WIDTH*NUM_NODE-1:0] o_delta_node,
  output logic                           o_valid
);

  localparam int CNT_W = $clog2(NUM_NODE) + 1;
  localparam int IDX_W = (NUM_NODE > 1) ? $clog2(NUM_NODE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NODE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] node_q      [NUM_NODE];
  logic [DATA_WIDTH-1:0] expected_q  [NUM_NODE];
  logic [DATA_WIDTH-1:0] staging     [NUM_NODE];
  logic [DATA_WIDTH-1:0] staging_nxt [NUM_NODE];
  logic [NUM_NODE-1:0]   mask_q;
  logic [CNT_W-1:0]      rd_cnt, wr_cnt;
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic                  accept, collect, last_collect;
  logic                  add_valid_in, add_valid_out;
  logic [DATA_WIDTH-1:0] add_a, add_b, add_out;

  assign accept       = i_valid && o_ready;
  assign rd_idx       = rd_cnt[IDX_W-1:0];
  assign wr_idx       = wr_cnt[IDX_W-1:0];
  // results are only taken while a vector is in flight
  assign collect      = add_valid_out && (state == S_ISSUE || state == S_DRAIN);
  assign last_collect = collect && (wr_cnt == LAST);

  // subtraction is an add with the sign of expected flipped
  assign add_a = node_q[rd_idx];
  assign add_b = {~expected_q[rd_idx][DATA_WIDTH-1], expected_q[rd_idx][DATA_WIDTH-2:0]};

  adder_floating_point32 #(
    .LATENCY (ADDER_LATENCY)
  ) u_adder (
    .clk       (clk),
    .rstn      (rst_n),
    .valid_in  (add_valid_in),
    .inA       (add_a),
    .inB       (add_b),
    .valid_out (add_valid_out),
    .outN      (add_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: if (rd_cnt == LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (last_collect) state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // DONE also reports ready so a held i_valid starts the next vector without a gap
  always_comb begin
    o_ready      = (state == S_IDLE) || (state == S_DONE);
    o_valid      = (state == S_DONE);
    add_valid_in = (state == S_ISSUE);
  end

  // staging with the arriving result merged, so the final result can reach o_delta_node
  // on the same edge that enters DONE
  always_comb begin
    for (int i = 0; i < NUM_NODE; i++) staging_nxt[i] = staging[i];
    if (collect) staging_nxt[wr_idx] = (MASK_ENABLE && !mask_q[wr_idx]) ? '0 : add_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODE; i++) begin
        node_q[i]     <= '0;
        expected_q[i] <= '0;
        staging[i]    <= '0;
      end
      mask_q       <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      o_delta_node <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_NODE; i++) begin
          node_q[i]     <= i_data_node[i*DATA_WIDTH +: DATA_WIDTH];
          expected_q[i] <= i_data_expected[i*DATA_WIDTH +: DATA_WIDTH];
        end
        mask_q <= i_action_mask;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (state == S_ISSUE) rd_cnt <= rd_cnt + CNT_W'(1);
        if (collect)          wr_cnt <= wr_cnt + CNT_W'(1);
      end
      for (int i = 0; i < NUM_NODE; i++) staging[i] <= staging_nxt[i];
      if (last_collect) begin
        for (int i = 0; i < NUM_NODE; i++) o_delta_node[i*DATA_WIDTH +: DATA_WIDTH] <= staging_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_back_propagation_output_layer_vector.sv
// tb/tb_back_propagation_output_layer_vector.sv - directed vector bench for back_propagation_output_layer_vector
module tb_back_propagation_output_layer_vector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic [127:0] i_data_node, i_data_expected;
  logic [3:0]   i_action_mask;
  logic         o_ready_m, o_valid_m, o_ready_nm, o_valid_nm;
  logic [127:0] o_delta_m, o_delta_nm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  back_propagation_output_layer_vector #(
    .DATA_WIDTH(32), .NUM_NODE(4), .ADDER_LATENCY(7), .MASK_ENABLE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data_node(i_data_node),
    .i_data_expected(i_data_expected), .i_action_mask(i_action_mask),
    .o_ready(o_ready_m), .o_delta_node(o_delta_m), .o_valid(o_valid_m)
  );

  back_propagation_output_layer_vector #(
    .DATA_WIDTH(32), .NUM_NODE(4), .ADDER_LATENCY(7), .MASK_ENABLE(1'b0)
  ) dut_nm (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data_node(i_data_node),
    .i_data_expected(i_data_expected), .i_action_mask(i_action_mask),
    .o_ready(o_ready_nm), .o_delta_node(o_delta_nm), .o_valid(o_valid_nm)
  );

  typedef struct {
    logic [127:0] node;
    logic [127:0] expd;
    logic [3:0]   mask;
    logic [127:0] exp_m;
    logic [127:0] exp_nm;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [127:0] pk(input logic [31:0] e0, input logic [31:0] e1,
                                      input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_data_node     = v.node;
    i_data_expected = v.expd;
    i_action_mask   = v.mask;
  endtask

  // called at a negedge with both DUTs idle
  task automatic run_vec(input vec_t v, input string tag);
    int lat_m, lat_nm, pulses;
    logic [127:0] cap_m, cap_nm;
    lat_m = 0; lat_nm = 0; pulses = 0; cap_m = '0; cap_nm = '0;
    check({tag, " ready"}, {126'd0, o_ready_m, o_ready_nm}, 128'd3);
    drive(v);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (o_valid_m) begin
        pulses++;
        if (lat_m == 0) begin lat_m = c; cap_m = o_delta_m; end
      end
      if (o_valid_nm && lat_nm == 0) begin lat_nm = c; cap_nm = o_delta_nm; end
      @(negedge clk);
    end
    check({tag, " latency"}, lat_m, 12);
    check({tag, " latency nomask"}, lat_nm, 12);
    check({tag, " pulse count"}, pulses, 1);
    check({tag, " delta masked"}, cap_m, v.exp_m);
    check({tag, " delta nomask"}, cap_nm, v.exp_nm);
    check({tag, " held"}, o_delta_m, v.exp_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int p1, p2, pulses, ign_lat;
    logic bad;
    logic [127:0] cap2;

    vecs[0] = '{pk(32'h40400000, 32'h3F800000, 32'h3F000000, 32'hC0000000),
                pk(32'h3F800000, 32'h3F800000, 32'h3E800000, 32'h3F800000), 4'b1111,
                pk(32'h40000000, 32'h00000000, 32'h3E800000, 32'hC0400000),
                pk(32'h40000000, 32'h00000000, 32'h3E800000, 32'hC0400000)};
    vecs[1] = '{vecs[0].node, vecs[0].expd, 4'b0100,
                pk(32'h00000000, 32'h00000000, 32'h3E800000, 32'h00000000),
                vecs[0].exp_nm};
    vecs[2] = '{pk(32'h7F800000, 32'h3FC00000, 32'h41200000, 32'h00000000),
                pk(32'h3F800000, 32'h3FC00000, 32'h40A00000, 32'h3F800000), 4'b1011,
                pk(32'h7F800000, 32'h00000000, 32'h00000000, 32'hBF800000),
                pk(32'h7F800000, 32'h00000000, 32'h40A00000, 32'hBF800000)};
    vecs[3] = '{pk(32'h3F800000, 32'h3F800000, 32'h40000000, 32'hBF800000),
                pk(32'h00000000, 32'hBF800000, 32'h40400000, 32'hBF800000), 4'b0001,
                pk(32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000),
                pk(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000)};

    rst_n = 1'b0; i_valid = 1'b0;
    i_data_node = '0; i_data_expected = '0; i_action_mask = '0;
    repeat (3) @(negedge clk);
    check("reset ready", {127'd0, o_ready_m}, 128'd1);
    check("reset valid", {126'd0, o_valid_m, o_valid_nm}, 128'd0);
    check("reset delta", o_delta_m | o_delta_nm, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // i_valid pulsed while busy must be ignored
    drive(vecs[0]);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    pulses = 0; ign_lat = 0; cap2 = '0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 3) begin drive(vecs[3]); i_valid = 1'b1; end
      if (c == 4) i_valid = 1'b0;
      if (c == 4) check("busy ready", {127'd0, o_ready_m}, 128'd0);
      if (o_valid_m) begin
        pulses++;
        if (ign_lat == 0) begin ign_lat = c; cap2 = o_delta_m; end
      end
      @(negedge clk);
    end
    check("ignore latency", ign_lat, 12);
    check("ignore pulses", pulses, 1);
    check("ignore delta", cap2, vecs[0].exp_m);

    // back-to-back with i_valid held high
    drive(vecs[0]);
    i_valid = 1'b1;
    @(negedge clk);
    drive(vecs[2]);
    p1 = 0; p2 = 0; bad = 1'b0; cap2 = '0;
    for (int c = 1; c <= 40; c++) begin
      if (p1 != 0 && c == p1 + 1) i_valid = 1'b0;
      if (o_valid_m) begin
        if (p1 == 0) p1 = c;
        else if (p2 == 0) begin p2 = c; cap2 = o_delta_m; end
      end else if (p1 != 0 && p2 == 0 && o_delta_m !== vecs[0].exp_m) begin
        bad = 1'b1;
      end
      @(negedge clk);
    end
    check("b2b first pulse", p1, 12);
    check("b2b spacing", p2 - p1, 12);
    check("b2b stable", {127'd0, bad}, 128'd0);
    check("b2b second delta", cap2, vecs[2].exp_m);

    // reset in the middle of a vector
    drive(vecs[3]);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset ready", {126'd0, o_ready_m, o_ready_nm}, 128'd3);
    check("midreset valid", {127'd0, o_valid_m}, 128'd0);
    check("midreset delta", o_delta_m, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_valid_m || o_valid_nm) pulses++;
      @(negedge clk);
    end
    check("midreset no pulse", pulses, 0);
    run_vec(vecs[1], "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
